// File: rtl/rocketcpu_uart_core.sv
// 8N1 UART engine: TX shifter, mid-bit sampling RX with FIFO, programmable
// baud divider and sticky frame/overrun flags behind a simple register port.
module rocketcpu_uart_core #(
  parameter int DEFAULT_DIV   = 104,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [15:0] div_q;
  logic        frame_err_q, overrun_q;
  logic [15:0] per;

  // Bit period never drops below 2 so the half-bit count is at least 1.
  assign per = (div_q < 16'd2) ? 16'd2 : div_q;

  // ---------------- TX ----------------
  logic        tx_busy_q, ser_tx_q;
  logic [9:0]  tx_shift_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_last, tx_busy, tx_accept;

  // The last clock of the stop bit counts as free so a queued write starts
  // its start bit right as the stop bit ends.
  assign tx_last      = tx_busy_q && (tx_cnt_q == 16'd0) && (tx_bit_q == 4'd9);
  assign tx_busy      = tx_busy_q && !tx_last;
  assign tx_accept    = reg_dat_we && !tx_busy;
  assign reg_dat_wait = reg_dat_we && tx_busy;
  assign ser_tx       = ser_tx_q;

  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      ser_tx_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (tx_accept) begin
      tx_shift_q <= {1'b1, reg_dat_di[7:0], 1'b0};
      ser_tx_q   <= 1'b0;
      tx_cnt_q   <= per - 16'd1;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == 16'd0) begin
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          ser_tx_q  <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
          ser_tx_q   <= tx_shift_q[1];
          tx_cnt_q   <= per - 16'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t   rx_state_q;
  logic [1:0]  rx_sync_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_data_q;
  logic        rx_push_q, rx_ferr_q;
  logic        rx_in, rx_tick;

  assign rx_in   = rx_sync_q[1];
  assign rx_tick = (rx_cnt_q <= 16'd1);

  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], ser_rx};
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_in) begin
          rx_cnt_q   <= {1'b0, per[15:1]};
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_tick) begin
          if (rx_in) rx_state_q <= RX_IDLE;
          else begin
            rx_cnt_q   <= per;
            rx_bit_q   <= '0;
            rx_state_q <= RX_DATA;
          end
        end else rx_cnt_q <= rx_cnt_q - 16'd1;
        RX_DATA: if (rx_tick) begin
          rx_data_q <= {rx_in, rx_data_q[7:1]};
          rx_cnt_q  <= per;
          rx_bit_q  <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end else rx_cnt_q <= rx_cnt_q - 16'd1;
        RX_STOP: if (rx_tick) begin
          rx_push_q  <= rx_in;
          rx_ferr_q  <= !rx_in;
          rx_state_q <= RX_IDLE;
        end else rx_cnt_q <= rx_cnt_q - 16'd1;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    fifo_mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, pop, push, ovr_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(RX_FIFO_DEPTH));
  assign pop        = reg_dat_re && !fifo_empty;
  assign push       = rx_push_q && (!fifo_full || pop);
  assign ovr_set    = rx_push_q && fifo_full && !pop;
  assign reg_dat_do = fifo_empty ? 32'hFFFF_FFFF : {24'b0, fifo_mem_q[rd_ptr_q]};

  always_ff @(posedge i_wb_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rx_data_q;
  end

  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- Divider / status ----------------
  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      div_q       <= 16'(DEFAULT_DIV);
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (reg_div_we[0]) div_q[7:0]  <= reg_div_di[7:0];
      if (reg_div_we[1]) div_q[15:8] <= reg_div_di[15:8];
      frame_err_q <= rx_ferr_q | (frame_err_q & ~reg_div_we[3]);
      overrun_q   <= ovr_set   | (overrun_q   & ~reg_div_we[3]);
    end
  end

  assign reg_div_do = {frame_err_q, overrun_q, 14'b0, div_q};

  logic unused_bits;
  assign unused_bits = ^{reg_div_di[31:16], reg_div_we[2], reg_dat_di[31:8]};

endmodule

// File: tb/tb_rocketcpu_uart_core.sv
// Directed bench for rocketcpu_uart_core: TX framing/back-to-back, RX queueing,
// overrun, frame error, false start and mid-frame reset.
module tb_rocketcpu_uart_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        ser_tx, ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di, reg_div_do;
  logic        reg_dat_we, reg_dat_re;
  logic [31:0] reg_dat_di, reg_dat_do;
  logic        reg_dat_wait;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rocketcpu_uart_core dut (
    .i_wb_clk    (clk),
    .reset       (reset),
    .ser_tx      (ser_tx),
    .ser_rx      (ser_rx),
    .reg_div_we  (reg_div_we),
    .reg_div_di  (reg_div_di),
    .reg_div_do  (reg_div_do),
    .reg_dat_we  (reg_dat_we),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_di  (reg_dat_di),
    .reg_dat_do  (reg_dat_do),
    .reg_dat_wait(reg_dat_wait)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_div(input logic [3:0] we, input logic [31:0] d);
    reg_div_we = we;
    reg_div_di = d;
    @(negedge clk);
    reg_div_we = 4'b0;
  endtask

  task automatic pop_one();
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
    #1;
  endtask

  // Drives one 8N1 frame at 8 clocks per bit, starting on a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = 1'b1;
  endtask

  initial begin
    logic [9:0] f1, f2;
    f1 = {1'b1, 8'hA5, 1'b0};
    f2 = {1'b1, 8'h5A, 1'b0};
    reset = 1'b1; ser_rx = 1'b1;
    reg_div_we = 4'b0; reg_div_di = '0;
    reg_dat_we = 1'b0; reg_dat_re = 1'b0; reg_dat_di = '0;
    tick(3);
    chk("rst_ser_tx", {31'b0, ser_tx}, 32'd1);
    chk("rst_div_do", reg_div_do, 32'd104);
    chk("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
    chk("rst_wait",   {31'b0, reg_dat_wait}, 32'd0);
    reset = 1'b0;
    tick(2);

    // TX at div=4: A5 then 5A held on the bus, back to back
    wr_div(4'b0011, 32'd4);
    chk("div_4", reg_div_do, 32'd4);
    reg_dat_we = 1'b1; reg_dat_di = 32'hA5;
    #1 chk("wait_idle", {31'b0, reg_dat_wait}, 32'd0);
    @(negedge clk);
    reg_dat_di = 32'h5A;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk($sformatf("tx1_bit%0d", i), {31'b0, ser_tx}, {31'b0, f1[i/4]});
      chk($sformatf("tx1_wait%0d", i), {31'b0, reg_dat_wait}, (i < 39) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    reg_dat_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk($sformatf("tx2_bit%0d", i), {31'b0, ser_tx}, {31'b0, f2[i/4]});
      @(negedge clk);
    end
    tick(3);
    chk("tx_idle", {31'b0, ser_tx}, 32'd1);

    // RX at div=8
    wr_div(4'b0011, 32'd8);
    send_byte(8'h3C, 1'b1);
    #1 chk("rx_3c", reg_dat_do, 32'h0000_003C);
    tick(4);
    pop_one();
    chk("rx_pop_empty", reg_dat_do, 32'hFFFF_FFFF);

    // 17 bytes into a 16-deep FIFO
    for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b1);
    tick(4);
    chk("ovr_set", reg_div_do, 32'h4000_0008);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ovr_pop%0d", j), reg_dat_do, 32'(j));
      pop_one();
    end
    chk("ovr_drained", reg_dat_do, 32'hFFFF_FFFF);
    wr_div(4'b1000, 32'h0);
    chk("ovr_clear", reg_div_do, 32'h0000_0008);

    // Stop bit held low
    send_byte(8'h55, 1'b0);
    tick(24);
    chk("ferr_noqueue", reg_dat_do, 32'hFFFF_FFFF);
    chk("ferr_set", reg_div_do, 32'h8000_0008);
    wr_div(4'b1000, 32'h0);
    chk("ferr_clear", reg_div_do, 32'h0000_0008);

    // 2-clock glitch is a false start
    ser_rx = 1'b0;
    tick(2);
    ser_rx = 1'b1;
    tick(30);
    chk("glitch_fifo", reg_dat_do, 32'hFFFF_FFFF);
    chk("glitch_flags", reg_div_do, 32'h0000_0008);

    // Reset in the middle of a TX and an RX frame
    reg_dat_we = 1'b1; reg_dat_di = 32'h00;
    @(negedge clk);
    reg_dat_we = 1'b0;
    ser_rx = 1'b0;
    tick(30);
    chk("mid_tx_low", {31'b0, ser_tx}, 32'd0);
    reset = 1'b1; ser_rx = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'b0, ser_tx}, 32'd1);
    chk("rst_mid_fifo", reg_dat_do, 32'hFFFF_FFFF);
    chk("rst_mid_div", reg_div_do, 32'd104);
    reset = 1'b0;
    tick(100);
    chk("post_rst_tx", {31'b0, ser_tx}, 32'd1);
    chk("post_rst_fifo", reg_dat_do, 32'hFFFF_FFFF);
    chk("post_rst_div", reg_div_do, 32'd104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
